// File: rtl/cacheline_assembler.sv
// rtl/cacheline_assembler.sv - merges 32-bit store writes into one open cacheline and emits it to the D-cache write port
//
// Purpose:
//   Collects byte-enabled payload writes into a single open line buffer
//   (data, byte mask, tag, index). The line is handed to a registered
//   output set when it fills, when a write to a different line arrives,
//   or when drain_i is asserted. The output set is offered downstream
//   over an enable_o/ready_i handshake and held stable until accepted.
//
// Ports:
//   clock_i, reset_i         clock (rising edge), asynchronous active-high reset
//   flushPipeline_i          discard the open (not yet emitted) line
//   enable_i, ready_o        write handshake; ready_o = !enable_o
//   payload_i, byteEnable_i  store data (byte 0 in bits [0:7]) and per-byte enables
//   tag_i, index_i, offset_i line address and byte offset of payload byte 0
//   drain_i                  force emission of the open line
//   enable_o, ready_i        line handshake towards the cache
//   cacheline_o, byteMask_o  assembled line and per-byte written mask
//   tag_o, index_o           address of the emitted line
//   linesFull_o, linesPartial_o  handshake counters (CACHELINE_ASSEMBLER_STATS_EN only)
//
// Optional feature macro: CACHELINE_ASSEMBLER_STATS_EN

module cacheline_assembler #(
    parameter int offsetSize          = 5,
    parameter int indexSize           = 8,
    parameter int tagSize             = 64 - (offsetSize + indexSize),
    parameter int cachelineSizeInBits = (2**offsetSize) * 8,
    parameter int payloadSizeBits     = 32
) (
    input  logic                             clock_i,
    input  logic                             reset_i,
    input  logic                             flushPipeline_i,
    input  logic                             enable_i,
    output logic                             ready_o,
    input  logic [0:payloadSizeBits-1]       payload_i,
    input  logic [0:payloadSizeBits/8-1]     byteEnable_i,
    input  logic [tagSize-1:0]               tag_i,
    input  logic [indexSize-1:0]             index_i,
    input  logic [offsetSize-1:0]            offset_i,
    input  logic                             drain_i,
    output logic                             enable_o,
    input  logic                             ready_i,
    output logic [0:cachelineSizeInBits-1]   cacheline_o,
    output logic [0:2**offsetSize-1]         byteMask_o,
    output logic [tagSize-1:0]               tag_o,
`ifdef CACHELINE_ASSEMBLER_STATS_EN
    output logic [0:15]                      linesFull_o,
    output logic [0:15]                      linesPartial_o,
`endif
    output logic [indexSize-1:0]             index_o
);

    localparam int LineBytes    = 2**offsetSize;
    localparam int PayloadBytes = payloadSizeBits / 8;

    // Open line buffer
    logic [0:cachelineSizeInBits-1] open_data_q;
    logic [0:LineBytes-1]           open_mask_q;
    logic [tagSize-1:0]             open_tag_q;
    logic [indexSize-1:0]           open_index_q;
    logic                           open_valid_q;

    // Output register set
    logic                           enable_q;
    logic [0:cachelineSizeInBits-1] line_q;
    logic [0:LineBytes-1]           mask_q;
    logic [tagSize-1:0]             tag_q;
    logic [indexSize-1:0]           index_q;

    // Merge result of the incoming write onto the open line (or onto an empty line)
    logic [0:cachelineSizeInBits-1] merged_data_d;
    logic [0:LineBytes-1]           merged_mask_d;
    logic                           accept;
    logic                           tag_match;
    logic                           merged_full;
    logic                           drain_fire;

    always_comb begin
        accept     = enable_i && !enable_q;
        tag_match  = open_valid_q && (open_tag_q == tag_i) && (open_index_q == index_i);
        drain_fire = drain_i && open_valid_q && !enable_q;

        // A write to a different (or no) line starts from a clean buffer.
        merged_data_d = tag_match ? open_data_q : '0;
        merged_mask_d = tag_match ? open_mask_q : '0;

        // Bytes landing beyond the end of the line never match any b, so they drop.
        for (int b = 0; b < LineBytes; b++) begin
            for (int k = 0; k < PayloadBytes; k++) begin
                if (byteEnable_i[k] && (int'(offset_i) + k == b)) begin
                    merged_data_d[8*b +: 8] = payload_i[8*k +: 8];
                    merged_mask_d[b]        = 1'b1;
                end
            end
        end

        merged_full = &merged_mask_d;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            open_data_q  <= '0;
            open_mask_q  <= '0;
            open_tag_q   <= '0;
            open_index_q <= '0;
            open_valid_q <= 1'b0;
            enable_q     <= 1'b0;
            line_q       <= '0;
            mask_q       <= '0;
            tag_q        <= '0;
            index_q      <= '0;
        end else begin
            if (enable_q && ready_i) begin
                enable_q <= 1'b0;
            end

            // Every emission below requires enable_q == 0, so it never
            // collides with the handshake clear above.
            if (flushPipeline_i) begin
                open_valid_q <= 1'b0;
                open_mask_q  <= '0;
            end else if (accept && open_valid_q && !tag_match) begin
                // Evict the old line; the new write opens a fresh one.
                enable_q     <= 1'b1;
                line_q       <= open_data_q;
                mask_q       <= open_mask_q;
                tag_q        <= open_tag_q;
                index_q      <= open_index_q;
                open_data_q  <= merged_data_d;
                open_mask_q  <= merged_mask_d;
                open_tag_q   <= tag_i;
                open_index_q <= index_i;
                open_valid_q <= 1'b1;
            end else if (accept) begin
                if (merged_full || drain_fire) begin
                    enable_q     <= 1'b1;
                    line_q       <= merged_data_d;
                    mask_q       <= merged_mask_d;
                    tag_q        <= tag_i;
                    index_q      <= index_i;
                    open_valid_q <= 1'b0;
                    open_mask_q  <= '0;
                end else begin
                    open_data_q  <= merged_data_d;
                    open_mask_q  <= merged_mask_d;
                    open_tag_q   <= tag_i;
                    open_index_q <= index_i;
                    open_valid_q <= 1'b1;
                end
            end else if (drain_fire) begin
                enable_q     <= 1'b1;
                line_q       <= open_data_q;
                mask_q       <= open_mask_q;
                tag_q        <= open_tag_q;
                index_q      <= open_index_q;
                open_valid_q <= 1'b0;
                open_mask_q  <= '0;
            end
        end
    end

    assign ready_o     = !enable_q;
    assign enable_o    = enable_q;
    assign cacheline_o = line_q;
    assign byteMask_o  = mask_q;
    assign tag_o       = tag_q;
    assign index_o     = index_q;

`ifdef CACHELINE_ASSEMBLER_STATS_EN
    logic [0:15] lines_full_q;
    logic [0:15] lines_partial_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            lines_full_q    <= '0;
            lines_partial_q <= '0;
        end else if (enable_q && ready_i) begin
            if (&mask_q) begin
                if (lines_full_q != 16'hFFFF) begin
                    lines_full_q <= lines_full_q + 16'd1;
                end
            end else begin
                if (lines_partial_q != 16'hFFFF) begin
                    lines_partial_q <= lines_partial_q + 16'd1;
                end
            end
        end
    end

    assign linesFull_o    = lines_full_q;
    assign linesPartial_o = lines_partial_q;
`endif

endmodule
